// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-drive bundle between an upstream word source, the
// select sequencer and the downstream consumer of the 8-to-1 mux output.
interface mux_sel_sequencer_if #(
  parameter int DIV_WIDTH = 8
);
  logic [7:0]           data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic [DIV_WIDTH-1:0] div;
  logic                 msb_first;
  logic                 abort;
  logic [7:0]           mux_in;
  logic [2:0]           mux_sel;
  logic                 bit_valid;
  logic                 bit_strobe;
  logic                 done;

  modport master (
    output data_in, data_valid, div, msb_first, abort,
    input  data_ready, mux_in, mux_sel, bit_valid, bit_strobe, done
  );

  modport slave (
    input  data_in, data_valid, div, msb_first, abort,
    output data_ready, mux_in, mux_sel, bit_valid, bit_strobe, done
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end: holds a word on the mux data inputs and walks
// the select through all eight positions, one programmable bit period each.
module mux_sel_sequencer #(
  parameter int DIV_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_sequencer_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [7:0]           word, word_nxt;
  logic [2:0]           sel, sel_nxt;
  logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nxt;
  logic [DIV_WIDTH-1:0] div_lat, div_lat_nxt;
  logic                 msb_lat, msb_lat_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 valid_r, valid_nxt;
  logic                 strobe_r, strobe_nxt;
  logic                 done_r, done_nxt;
  logic                 ready;

  // abort must block an accept in the same cycle, so ready is decoded combinationally
  assign ready = (state == IDLE) && !bus.abort;

  always_comb begin
    state_nxt   = state;
    word_nxt    = word;
    sel_nxt     = sel;
    div_cnt_nxt = div_cnt;
    div_lat_nxt = div_lat;
    msb_lat_nxt = msb_lat;
    bit_cnt_nxt = bit_cnt;
    strobe_nxt  = 1'b0;
    done_nxt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.data_valid && ready) begin
          word_nxt    = bus.data_in;
          div_lat_nxt = bus.div;
          msb_lat_nxt = bus.msb_first;
          sel_nxt     = bus.msb_first ? 3'd7 : 3'd0;
          div_cnt_nxt = bus.div;
          bit_cnt_nxt = 3'd0;
          strobe_nxt  = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (div_cnt == '0) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            sel_nxt     = msb_lat ? sel - 3'd1 : sel + 3'd1;
            div_cnt_nxt = div_lat;
            bit_cnt_nxt = bit_cnt + 3'd1;
            strobe_nxt  = 1'b1;
          end
        end else begin
          div_cnt_nxt = div_cnt - DIV_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    valid_nxt = (state_nxt == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      word     <= 8'h00;
      sel      <= 3'd0;
      div_cnt  <= '0;
      div_lat  <= '0;
      msb_lat  <= 1'b0;
      bit_cnt  <= 3'd0;
      valid_r  <= 1'b0;
      strobe_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      sel      <= sel_nxt;
      div_cnt  <= div_cnt_nxt;
      div_lat  <= div_lat_nxt;
      msb_lat  <= msb_lat_nxt;
      bit_cnt  <= bit_cnt_nxt;
      valid_r  <= valid_nxt;
      strobe_r <= strobe_nxt;
      done_r   <= done_nxt;
    end
  end

  assign bus.data_ready = ready;
  assign bus.mux_in     = word;
  assign bus.mux_sel    = sel;
  assign bus.bit_valid  = valid_r;
  assign bus.bit_strobe = strobe_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed and randomized frames checked cycle by cycle against a reference
// that derives each cycle's select, strobe and done from the frame position.
module tb_mux_sel_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mux_sel_sequencer_if #(.DIV_WIDTH(8)) m();
  mux_sel_sequencer #(.DIV_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mux_in"}, 32'(m.mux_in), 32'h00);
    check({tag, "_sel"}, 32'(m.mux_sel), 32'd0);
    check({tag, "_bit_valid"}, 32'(m.bit_valid), 32'd0);
    check({tag, "_strobe"}, 32'(m.bit_strobe), 32'd0);
    check({tag, "_done"}, 32'(m.done), 32'd0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first frame cycle.
  task automatic accept(input logic [7:0] d, input int dv, input logic msb, input bit hold);
    m.data_in    = d;
    m.div        = 8'(dv);
    m.msb_first  = msb;
    m.data_valid = 1'b1;
    #1 check("ready_before_accept", 32'(m.data_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) m.data_valid = 1'b0;
  endtask

  // Reference: cycle k of a frame is bit k/(div+1); the strobe marks k%(div+1)==0.
  task automatic frame(input logic [7:0] d, input int dv, input logic msb, input bit perturb,
                       input int stop_k, input bit stop_is_reset, input bit hold_next,
                       input logic [7:0] nd);
    int total;
    int b;
    logic [2:0] esel;
    total = 8 * (dv + 1);
    for (int k = 0; k < total; k++) begin
      b = k / (dv + 1);
      esel = msb ? 3'(7 - b) : 3'(b);
      check("sel", 32'(m.mux_sel), 32'(esel));
      check("mux_in", 32'(m.mux_in), 32'(d));
      check("bit_valid", 32'(m.bit_valid), 32'd1);
      check("strobe", 32'(m.bit_strobe), 32'((k % (dv + 1)) == 0));
      check("done_in_frame", 32'(m.done), 32'd0);
      check("ready_in_frame", 32'(m.data_ready), 32'd0);
      check("mux_out", 32'(m.mux_in[m.mux_sel]), 32'(d[esel]));
      if (k == stop_k) begin
        if (stop_is_reset) begin
          #2 rst_n = 1'b0;
          #1 check_reset_vals("async_reset");
          check("ready_in_reset", 32'(m.data_ready), 32'd1);
        end else begin
          m.abort = 1'b1;
          @(negedge clk);
          check("abort_bit_valid", 32'(m.bit_valid), 32'd0);
          check("abort_done", 32'(m.done), 32'd0);
          check("abort_strobe", 32'(m.bit_strobe), 32'd0);
          check("abort_ready_blocked", 32'(m.data_ready), 32'd0);
          check("abort_sel_hold", 32'(m.mux_sel), 32'(esel));
          check("abort_mux_in_hold", 32'(m.mux_in), 32'(d));
          m.abort = 1'b0;
          #1 check("ready_after_abort", 32'(m.data_ready), 32'd1);
        end
        return;
      end
      if (hold_next && k == 0) m.data_in = nd;
      if (perturb) begin
        if (k < total - 1) begin
          m.div        = (k == 0) ? 8'd5 : 8'($urandom_range(0, 7));
          m.msb_first  = ~m.msb_first;
          m.data_in    = 8'h11;
          m.data_valid = k[0];
        end else begin
          m.data_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("done_pulse", 32'(m.done), 32'd1);
    check("done_bit_valid", 32'(m.bit_valid), 32'd0);
    check("done_strobe", 32'(m.bit_strobe), 32'd0);
    check("done_ready", 32'(m.data_ready), 32'd1);
    check("done_sel_hold", 32'(m.mux_sel), msb ? 32'd0 : 32'd7);
    check("done_mux_in_hold", 32'(m.mux_in), 32'(d));
  endtask

  initial begin
    logic [7:0] rd;
    int rdv;
    logic rmsb;
    m.data_in = 8'h00; m.data_valid = 1'b0; m.div = 8'd0; m.msb_first = 1'b0; m.abort = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(m.data_ready), 32'd1);
    check_reset_vals("post_reset");
    @(negedge clk);

    // LSB-first, one clock per bit
    accept(8'hA5, 0, 1'b0, 1'b0);
    frame(8'hA5, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("done_single_pulse", 32'(m.done), 32'd0);

    // MSB-first, four clocks per bit
    accept(8'h3C, 3, 1'b1, 1'b0);
    frame(8'h3C, 3, 1'b1, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Back-to-back: second word accepted in the done cycle
    accept(8'hFF, 1, 1'b0, 1'b1);
    frame(8'hFF, 1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    m.data_valid = 1'b0;
    frame(8'h00, 1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Mid-frame div/msb_first changes and ignored data_valid
    accept(8'hC6, 0, 1'b1, 1'b0);
    frame(8'hC6, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("no_capture_after_perturb", 32'(m.bit_valid), 32'd0);

    // Abort at bit 3 of a div=2 frame
    accept(8'h96, 2, 1'b0, 1'b0);
    frame(8'h96, 2, 1'b0, 1'b0, 9, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("abort_no_done_later", 32'(m.done), 32'd0);
    check("abort_stays_idle", 32'(m.bit_valid), 32'd0);

    // abort wins over data_valid in IDLE
    m.abort = 1'b1; m.data_valid = 1'b1; m.data_in = 8'h77;
    #1 check("idle_abort_ready", 32'(m.data_ready), 32'd0);
    @(negedge clk);
    check("idle_abort_no_accept", 32'(m.bit_valid), 32'd0);
    check("idle_abort_mux_in", 32'(m.mux_in), 32'h96);
    check("idle_abort_strobe", 32'(m.bit_strobe), 32'd0);
    m.abort = 1'b0; m.data_valid = 1'b0;
    @(negedge clk);

    // Async reset between edges at bit 5
    accept(8'h5B, 1, 1'b0, 1'b0);
    frame(8'h5B, 1, 1'b0, 1'b0, 10, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check_reset_vals("held_in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_no_done", 32'(m.done), 32'd0);
    check("post_reset_idle", 32'(m.bit_valid), 32'd0);
    accept(8'h81, 0, 1'b1, 1'b0);
    frame(8'h81, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom);
      rdv  = int'($urandom_range(0, 3));
      rmsb = 1'($urandom_range(0, 1));
      accept(rd, rdv, rmsb, 1'b0);
      frame(rd, rdv, rmsb, i[0], -1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
